// File: rtl/dmem_mmio.sv
// dmem_mmio: data memory with a small MMIO block for the core's data port.
//   0x0xxxxxxx : word RAM (aliases modulo RAM size)
//   0xF0000000 : CONSOLE_TX - a store pushes a byte into the console FIFO
//   0xF0000004 : STATUS     - {overflow, full, empty}; storing bit 2 set clears overflow
//   0xF0000008 : CYCLE      - free-running counter, only present with DMEM_MMIO_CYCLE_EN
// Define DMEM_MMIO_CYCLE_EN to build the CYCLE counter; otherwise that address reads 0.
module dmem_mmio #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    localparam logic [31:0] ADDR_TX     = 32'hF000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'hF000_0004;
`ifdef DMEM_MMIO_CYCLE_EN
    localparam logic [31:0] ADDR_CYCLE  = 32'hF000_0008;
`endif

    logic [31:0]        ram [RAM_WORDS];
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    logic               sel_ram;
    logic               sel_tx;
    logic               sel_status;
    logic [RAM_AW-1:0]  ram_idx;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push_req;
    logic               push_ok;
    logic               ovf_event;
    logic               status_clr;

    assign sel_ram    = (addr[31:28] == 4'h0);
    assign sel_tx     = (addr == ADDR_TX);
    assign sel_status = (addr == ADDR_STATUS);
    assign ram_idx    = addr[RAM_AW+1:2];

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign out_valid  = !fifo_empty;
    assign out_data   = out_valid ? fifo_mem[rd_ptr] : 8'h00;

    // A push into a full FIFO only lands if the head leaves on the same edge.
    assign pop        = out_valid && out_ready;
    assign push_req   = memwrite && sel_tx;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_event  = push_req && fifo_full && !pop;
    assign status_clr = memwrite && sel_status && writedata[2];

    // RAM word write; contents survive reset but stores during reset are dropped.
    always_ff @(posedge clk) begin
        if (!reset && memwrite && sel_ram) begin
            ram[ram_idx] <= writedata;
        end
    end

    // FIFO byte storage, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            fifo_mem[wr_ptr] <= writedata[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            overflow <= (overflow && !status_clr) || ovf_event;
        end
    end

`ifdef DMEM_MMIO_CYCLE_EN
    logic        sel_cycle;
    logic [31:0] cycle_count;

    assign sel_cycle = (addr == ADDR_CYCLE);

    // Free-running cycle counter; a software store wins over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (memwrite && sel_cycle) begin
            cycle_count <= writedata;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

    // Load mux: RAM word, STATUS or CYCLE; everything else reads zero.
    always_comb begin
        readdata = '0;
        if (sel_ram) begin
            readdata = ram[ram_idx];
        end else if (sel_status) begin
            readdata = {29'b0, overflow, fifo_full, fifo_empty};
        end
`ifdef DMEM_MMIO_CYCLE_EN
        else if (sel_cycle) begin
            readdata = cycle_count;
        end
`endif
    end

endmodule
